// File: rtl/fft_col_writer.sv
// Collects four 8-word MAC result groups into a 32-word column buffer, then streams the column out.
// Optional FFTC_WR_BITREV_EN: output addresses follow the 5-bit bit-reversed drain count.
module fft_col_writer #(
    parameter int WORD_W  = 64,
    parameter int FRAME_N = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res_valid,
    input  logic [8*WORD_W-1:0]   res_data,
    output logic                  res_ready,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_W-1:0]     m_data,
    output logic [4:0]            m_index,
    output logic                  m_last,
    output logic                  frame_done,
    output logic                  ovf_err
);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [4:0]        drain_q, drain_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              accept, m_fire;
    logic [WORD_W-1:0] buf_q [FRAME_N];

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        res_ready = (state_q == FILL);
        m_valid   = (state_q == DRAIN);
        m_last    = (state_q == DRAIN) && (drain_q == 5'd31);
        accept    = res_valid && res_ready;
        m_fire    = m_valid && m_ready;
        // A group offered while draining is lost; remember that it happened.
        ovf_d     = ovf_q | (res_valid && !res_ready);
        case (state_q)
            FILL: begin
                if (accept) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_fire) begin
                    if (m_last) begin
                        state_d = FILL;
                        drain_d = 5'd0;
                        phase_d = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + 5'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            phase_q <= 2'd0;
            drain_q <= 5'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Buffer is deliberately not reset; MAC k out1 lands at 8k+p, out2 at 8k+4+p.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            for (int k = 0; k < 4; k++) begin
                buf_q[{k[1:0], 1'b0, phase_q}] <= res_data[(2*k)*WORD_W +: WORD_W];
                buf_q[{k[1:0], 1'b1, phase_q}] <= res_data[(2*k+1)*WORD_W +: WORD_W];
            end
        end
    end

`ifdef FFTC_WR_BITREV_EN
    always_comb begin
        for (int i = 0; i < 5; i++) m_index[i] = drain_q[4-i];
    end
`else
    assign m_index = drain_q;
`endif

    assign m_data     = buf_q[m_index];
    assign frame_done = done_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_fft_col_writer.sv
// Randomized and directed bench for fft_col_writer against a frame-level reference model.
module tb_fft_col_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic         res_valid;
    logic [511:0] res_data;
    logic         res_ready;
    logic         m_valid;
    logic         m_ready;
    logic [63:0]  m_data;
    logic [4:0]   m_index;
    logic         m_last;
    logic         frame_done;
    logic         ovf_err;

    fft_col_writer #(.WORD_W(64), .FRAME_N(32)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_index(m_index), .m_last(m_last),
        .frame_done(frame_done), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycles = 0;
    bit started = 0;

    // Reference model: frame-level bookkeeping
    logic [63:0] mbuf [32];
    bit          filling = 1;
    int          groups = 0;
    int          words = 0;
    bit          ovf = 0;
    bit          done_exp = 0;

    logic [63:0] cap [32];
    logic [4:0]  seq [32];
    int          hs_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycles);
        end
    endtask

    function automatic logic [4:0] exp_index(input int w);
        logic [4:0] n, r;
        n = w[4:0];
`ifdef FFTC_WR_BITREV_EN
        for (int i = 0; i < 5; i++) r[i] = n[4-i];
`else
        r = n;
`endif
        return r;
    endfunction

    function automatic logic [511:0] make_pat(input int p, input int off);
        logic [511:0] d;
        for (int j = 0; j < 8; j++) d[64*j +: 64] = 64'(off + p*16 + j);
        return d;
    endfunction

    always @(posedge clk) begin
        cycles++;
        if (cycles > 50000) begin
            $display("FAIL watchdog: cycle budget exhausted");
            $fatal(1);
        end
        if (reset) begin
            filling = 1; groups = 0; words = 0; ovf = 0; done_exp = 0;
        end else begin
            done_exp = 0;
            if (filling) begin
                if (res_valid) begin
                    for (int k = 0; k < 4; k++) begin
                        mbuf[k*8 + groups]     = res_data[(2*k)*64 +: 64];
                        mbuf[k*8 + 4 + groups] = res_data[(2*k+1)*64 +: 64];
                    end
                    groups++;
                    if (groups == 4) begin filling = 0; groups = 0; end
                end
            end else begin
                if (res_valid) ovf = 1;
                if (m_ready) begin
                    words++;
                    if (words == 32) begin filling = 1; words = 0; done_exp = 1; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("res_ready", 64'(res_ready), 64'(filling));
            check("m_valid", 64'(m_valid), 64'(!filling));
            check("m_last", 64'(m_last), 64'(!filling && words == 31));
            check("frame_done", 64'(frame_done), 64'(done_exp));
            check("ovf_err", 64'(ovf_err), 64'(ovf));
            if (!filling) begin
                check("m_index", 64'(m_index), 64'(exp_index(words)));
                check("m_data", m_data, mbuf[exp_index(words)]);
                if (m_ready) begin
                    cap[m_index] = m_data;
                    seq[words]   = m_index;
                    hs_count++;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1; res_valid = 0; m_ready = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        started = 1;
    endtask

    task automatic send_group(input logic [511:0] d);
        res_valid = 1; res_data = d;
        @(posedge clk); #1;
        res_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // mode 0: ready always; 1: ready toggles 0101..; flood: res_valid held high
    task automatic drain(input int mode, input bit flood, output int len);
        bit done = 0;
        len = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            m_ready = (mode == 0) ? 1'b1 : 1'(c % 2);
            if (flood) begin res_valid = 1; res_data = {16{$urandom}}; end
            @(posedge clk); #1;
            len = c + 1;
            if (frame_done) done = 1;
        end
        res_valid = 0; m_ready = 0;
        if (!done) check("drain_timeout", 64'd0, 64'd1);
    endtask

    int len;

    initial begin
        reset = 1; res_valid = 0; res_data = '0; m_ready = 0;
        do_reset();

        // Back-to-back pattern frame, ready always high
        for (int i = 0; i < 32; i++) cap[i] = '1;
        hs_count = 0;
        for (int p = 0; p < 4; p++) send_group(make_pat(p, 0));
        check("valid_after_4th", 64'(m_valid), 64'd1);
        drain(0, 0, len);
        check("drain_len_full", 64'(len), 64'd32);
        check("hs_count", 64'(hs_count), 64'd32);
        check("idx0", cap[0], 64'h00);
        check("idx4", cap[4], 64'h01);
        check("idx9", cap[9], 64'h12);
        check("idx31", cap[31], 64'h37);
`ifdef FFTC_WR_BITREV_EN
        check("seq1", 64'(seq[1]), 64'd16);
        check("seq2", 64'(seq[2]), 64'd8);
`else
        check("seq1", 64'(seq[1]), 64'd1);
        check("seq2", 64'(seq[2]), 64'd2);
`endif
        check("seq31", 64'(seq[31]), 64'd31);

        // Toggling ready: 32 stalls interleaved with 32 handshakes
        for (int p = 0; p < 4; p++) send_group(make_pat(p, 'h40));
        drain(1, 0, len);
        check("drain_len_toggle", 64'(len), 64'd64);

        // Groups offered during drain are dropped and flagged
        for (int p = 0; p < 4; p++) send_group(make_pat(p, 'h80));
        drain(0, 1, len);
        check("ovf_set", 64'(ovf_err), 64'd1);
        for (int p = 0; p < 4; p++) send_group({16{$urandom}});
        drain(0, 0, len);
        check("ovf_sticky", 64'(ovf_err), 64'd1);

        // Reset mid-fill abandons the partial frame
        send_group({8{64'hAAAA_0000_0000_0000}});
        send_group({8{64'hBBBB_0000_0000_0000}});
        do_reset();
        check("ovf_cleared", 64'(ovf_err), 64'd0);
        for (int p = 0; p < 4; p++) send_group(make_pat(p, 'h100));
        drain(0, 0, len);
        check("after_reset_idx9", cap[9], 64'h112);
        check("after_reset_idx0", cap[0], 64'h100);

        // Idle gaps between groups give the same frame
        for (int i = 0; i < 32; i++) cap[i] = '1;
        for (int p = 0; p < 4; p++) begin send_group(make_pat(p, 0)); if (p < 3) idle(3); end
        drain(0, 0, len);
        check("gap_idx9", cap[9], 64'h12);
        check("gap_idx4", cap[4], 64'h01);
        check("gap_idx0", cap[0], 64'h00);

        // Fully random traffic, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            res_valid = 1'($urandom_range(0, 1));
            res_data  = {16{$urandom}};
            m_ready   = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        reset = 0; res_valid = 0; m_ready = 0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_col_writer.md
FFT_COL_WRITER -- requirements
Module: fft_col_writer

Interface
REQ-001 SHALL have parameter WORD_W, default 64, meaning the width of one complex word ({real[63:32], imag[31:0]}, IEEE-754 single each).
REQ-002 SHALL have parameter FRAME_N, default 32, meaning the words per column frame; the value is fixed at 32.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port res_valid, input, 1 bit: the MAC result group on res_data is valid this cycle.
REQ-006 SHALL have port res_data, input, 8*WORD_W bits: slot j=2k+o holds MAC k (0..3), output o (0=out1, 1=out2), at bits [64j+63:64j].
REQ-007 SHALL have port res_ready, output, 1 bit: the block accepts result groups.
REQ-008 SHALL have port m_valid, output, 1 bit: the output stream word is valid.
REQ-009 SHALL have port m_ready, input, 1 bit: the downstream consumer accepts the output word.
REQ-010 SHALL have port m_data, output, WORD_W bits: the output stream word.
REQ-011 SHALL have port m_index, output, 5 bits: the buffer address of m_data.
REQ-012 SHALL have port m_last, output, 1 bit: m_data is the final word of the frame.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame has fully drained.
REQ-014 SHALL have port ovf_err, output, 1 bit: sticky flag set when a result group is offered and not accepted.

Function
REQ-015 SHALL contain a 32 x WORD_W register buffer, a 2-bit phase counter, a 5-bit drain counter, and an FSM with states FILL and DRAIN.
REQ-016 In FILL: res_ready=1 and m_valid=0.
REQ-017 In DRAIN: res_ready=0 and m_valid=1.
REQ-018 A group is accepted on res_valid&&res_ready; at phase p, MAC k out1 SHALL be written to address 8k+p and out2 to address 8k+4+p.
REQ-019 The phase counter SHALL increment only on an accepted group and wrap 3->0.
REQ-020 An accepted group at phase 3 SHALL transition the FSM to DRAIN, with m_valid high on the next cycle (1-cycle latency).
REQ-021 res_valid low in FILL SHALL hold the phase counter, the buffer and the state.
REQ-022 m_data SHALL equal buffer[m_index], with m_index derived from the drain counter (REQ-035/036).
REQ-023 m_data and m_index SHALL stay stable while m_valid&&!m_ready.
REQ-024 The drain counter SHALL advance only on m_valid&&m_ready.
REQ-025 m_last SHALL be high when the drain counter equals 31.
REQ-026 A handshake with m_last high SHALL return the FSM to FILL, reset both counters to 0, and pulse frame_done high for exactly the following cycle.
REQ-027 The first group of the next frame SHALL be accepted no earlier than the cycle after the last drain handshake; there is no overlap of fill and drain.
REQ-028 res_valid high while res_ready is low SHALL drop the group, leave buffer, counters and state unchanged, and set ovf_err on the next edge.
REQ-029 ovf_err SHALL be cleared only by reset.

Reset
REQ-030 On reset high at a clock edge, the FSM SHALL go to FILL and both counters to 0.
REQ-031 Reset SHALL drive m_valid=0, res_ready=1 (from the first cycle after the edge), m_last=0, frame_done=0 and ovf_err=0.
REQ-032 Reset SHALL NOT clear the buffer contents, and m_data is don't-care while m_valid=0.
REQ-033 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the partial frame with no frame_done pulse.
REQ-034 Reset SHALL take priority over every simultaneous handshake.

Configuration
REQ-035 With macro FFTC_WR_BITREV_EN defined, m_index SHALL be the 5-bit bit-reversal of the drain counter (0,16,8,24,4,...,31), and m_last SHALL still be keyed to drain counter 31.
REQ-036 Without FFTC_WR_BITREV_EN, m_index SHALL equal the drain counter (natural order 0..31), and no reversal logic is present.

Verification
REQ-037 Reset, then 4 back-to-back groups with slot j of phase p = 64'h(p*16+j) and m_ready=1 -> m_valid rises 1 cycle after the 4th group; index 0 carries 0x00, index 4 carries 0x01, index 9 carries 0x12; 32 words, m_last only on the 32nd, frame_done 1 cycle after it.
REQ-038 m_ready toggling 1010... during drain -> m_data/m_index held during every stall; total drain takes 64 cycles; no word lost or duplicated.
REQ-039 res_valid held high during DRAIN -> ovf_err=1 and stays 1; the drained data equals the first frame; the next frame fills normally after drain.
REQ-040 Reset after 2 accepted groups, then 4 new groups -> drained frame contains only the new-group data at the addresses written by those 4 groups; no frame_done before the reset.
REQ-041 Build with FFTC_WR_BITREV_EN, same stimulus as REQ-037 -> m_index sequence 0,16,8,24,...,15,31; m_last on the 32nd word (index 31).
REQ-042 res_valid gaps of 3 idle cycles between groups -> identical buffer contents to REQ-037.
